seq_bcd_ctrl: RTL

SEQ_BCD_CTRL -- requirements
Module: seq_bcd_ctrl

---
 rtl/seq_bcd_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/seq_bcd_ctrl.sv
// seq_bcd_ctrl: sequential binary-to-BCD converter (shift-and-add-3).
// An operand is accepted in IDLE. It is converted over WIDTH SHIFT cycles,
// and the result is held in DONE until the consumer takes it.
// Optional leading-zero blanking is compiled in with `define SEQ_BCD_BLANK_EN.
module seq_bcd_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic [DIGITS-1:0]     digit_blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                    state;
  logic [WIDTH-1:0]          opnd;
  logic [4*DIGITS-1:0]       dig;
  logic [4*DIGITS-1:0]       adj;
  logic [4*DIGITS+WIDTH-1:0] sh;
  logic [CW-1:0]             cnt;

  // Add 3 to each digit >= 5, then shift {digits, operand} left by one bit
  always_comb begin
    adj = dig;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dig[4*i +: 4] >= 4'd5) adj[4*i +: 4] = dig[4*i +: 4] + 4'd3;
    end
    sh = {adj, opnd} << 1;
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opnd      <= '0;
      dig       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd     <= in_data;
            dig      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          dig <= sh[4*DIGITS+WIDTH-1:WIDTH];
          opnd <= sh[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bcd = dig;

`ifdef SEQ_BCD_BLANK_EN
  logic zero_run;

  // Blank digit i (i >= 1) when it and all higher digits are zero
  always_comb begin
    digit_blank = '0;
    zero_run    = 1'b1;
    if (out_valid) begin
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
        zero_run       = zero_run & (dig[4*i +: 4] == 4'd0);
        digit_blank[i] = zero_run;
      end
    end
  end
`else
  assign digit_blank = '0;
`endif

endmodule
